// File: rtl/alu_operand_stage.sv
// ============================================================================
//  Module   : alu_operand_stage
//  Purpose  : ID/EX pipeline register with EX/MEM and MEM/WB operand
//             forwarding and load-use hazard detection, feeding the ALU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_operand_stage #(
   parameter int WIDTH   = 32,
   parameter int REGBITS = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stall,
   input  logic               flush,
   input  logic               id_valid,
   input  logic [WIDTH-1:0]   id_BussA,
   input  logic [WIDTH-1:0]   id_BussB,
   input  logic [WIDTH-1:0]   id_imm,
   input  logic               id_ALUSrc,
   input  logic               id_usesRt,
   input  logic [1:0]         id_ALUControl,
   input  logic [REGBITS-1:0] id_rs,
   input  logic [REGBITS-1:0] id_rt,
   input  logic [REGBITS-1:0] id_rd,
   input  logic               id_RegWrite,
   input  logic               id_MemRead,
   input  logic               id_MemWrite,
   input  logic               id_MemToReg,
   input  logic               exmem_RegWrite,
   input  logic [REGBITS-1:0] exmem_rd,
   input  logic [WIDTH-1:0]   exmem_result,
   input  logic               memwb_RegWrite,
   input  logic [REGBITS-1:0] memwb_rd,
   input  logic [WIDTH-1:0]   memwb_result,
   output logic [WIDTH-1:0]   BussA,
   output logic [WIDTH-1:0]   BussB,
   output logic [1:0]         ALUControl,
   output logic [WIDTH-1:0]   ex_storeData,
   output logic [REGBITS-1:0] ex_rd,
   output logic               ex_valid,
   output logic               ex_RegWrite,
   output logic               ex_MemRead,
   output logic               ex_MemWrite,
   output logic               ex_MemToReg,
   output logic               load_use
);

   logic               r_valid;
   logic               r_reg_write;
   logic               r_mem_read;
   logic               r_mem_write;
   logic               r_mem_to_reg;
   logic               r_alu_src;
   logic [1:0]         r_alu_control;
   logic [REGBITS-1:0] r_rs;
   logic [REGBITS-1:0] r_rt;
   logic [REGBITS-1:0] r_rd;
   logic [WIDTH-1:0]   r_buss_a;
   logic [WIDTH-1:0]   r_buss_b;
   logic [WIDTH-1:0]   r_imm;

   logic               w_bubble;
   logic [WIDTH-1:0]   w_fwd_a;
   logic [WIDTH-1:0]   w_fwd_b;

   // A load in EX whose destination is read by the ID instruction
   always_comb begin
      load_use = r_valid && r_mem_read && (r_rd != '0) && id_valid &&
                 ((id_rs == r_rd) || (id_usesRt && (id_rt == r_rd)));
   end

   assign w_bubble = flush || (!stall && load_use);

   always_ff @(posedge clk or posedge reset) begin
      if (reset || w_bubble) begin
         r_valid       <= 1'b0;
         r_reg_write   <= 1'b0;
         r_mem_read    <= 1'b0;
         r_mem_write   <= 1'b0;
         r_mem_to_reg  <= 1'b0;
         r_alu_src     <= 1'b0;
         r_alu_control <= 2'b00;
         r_rs          <= '0;
         r_rt          <= '0;
         r_rd          <= '0;
         r_buss_a      <= '0;
         r_buss_b      <= '0;
         r_imm         <= '0;
      end else if (!stall) begin
         r_valid       <= id_valid;
         r_reg_write   <= id_RegWrite;
         r_mem_read    <= id_MemRead;
         r_mem_write   <= id_MemWrite;
         r_mem_to_reg  <= id_MemToReg;
         r_alu_src     <= id_ALUSrc;
         r_alu_control <= id_ALUControl;
         r_rs          <= id_rs;
         r_rt          <= id_rt;
         r_rd          <= id_rd;
         r_buss_a      <= id_BussA;
         r_buss_b      <= id_BussB;
         r_imm         <= id_imm;
      end
   end

   // Younger producer (EX/MEM) takes precedence; register 0 is never forwarded
   always_comb begin
      w_fwd_a = r_buss_a;
      if (exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == r_rs)) begin
         w_fwd_a = exmem_result;
      end else if (memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == r_rs)) begin
         w_fwd_a = memwb_result;
      end

      w_fwd_b = r_buss_b;
      if (exmem_RegWrite && (exmem_rd != '0) && (exmem_rd == r_rt)) begin
         w_fwd_b = exmem_result;
      end else if (memwb_RegWrite && (memwb_rd != '0) && (memwb_rd == r_rt)) begin
         w_fwd_b = memwb_result;
      end
   end

   assign BussA        = w_fwd_a;
   assign BussB        = r_alu_src ? r_imm : w_fwd_b;
   assign ex_storeData = w_fwd_b;
   assign ALUControl   = r_alu_control;
   assign ex_rd        = r_rd;
   assign ex_valid     = r_valid;
   assign ex_RegWrite  = r_reg_write;
   assign ex_MemRead   = r_mem_read;
   assign ex_MemWrite  = r_mem_write;
   assign ex_MemToReg  = r_mem_to_reg;

endmodule

`default_nettype wire
